// File: rtl/piso_serializer.sv
// piso_serializer: parametrised parallel-in/serial-out shift register.
// Accepts a WIDTH-bit word over a valid/ready handshake and presents it one
// bit at a time, either MSB first or LSB first. The bit order is chosen per
// frame. A downstream shift enable consumes each bit, and first/last flags
// mark the frame boundaries.
// Optional build macro PISO_PARITY_EN: appends an even-parity bit after the
// last data bit, which makes the frame WIDTH+1 bits long.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic             i_lsb_first,
    input  logic             i_shift_en,
    output logic             o_sdata,
    output logic             o_svalid,
    output logic             o_first,
    output logic             o_last,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lsb_q, lsb_d;
    logic             first_q, first_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic onLast;
    logic loadReady;
    logic accept;
    logic headBit;
    logic curBit;

    assign onLast    = (state_q == SHIFT) && (cnt_q == CNT_ONE);
    // The last bit being consumed frees the block in the same cycle, so a new
    // word can follow without a gap cycle.
    assign loadReady = (state_q == IDLE) || (onLast && i_shift_en);
    assign accept    = i_load_valid && loadReady;

    assign headBit = lsb_q ? shreg_q[0] : shreg_q[WIDTH-1];
`ifdef PISO_PARITY_EN
    assign curBit  = (cnt_q == CNT_ONE) ? parity_q : headBit;
`else
    assign curBit  = headBit;
`endif

    assign o_load_ready = loadReady;
    assign o_sdata      = (state_q == SHIFT) && curBit;
    assign o_svalid     = (state_q == SHIFT);
    assign o_busy       = (state_q == SHIFT);
    assign o_first      = (state_q == SHIFT) && first_q;
    assign o_last       = onLast;

    // Next-state logic: a load overrides the consume of the final bit, and a
    // consume shifts the word toward the head.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        lsb_d    = lsb_q;
        first_d  = first_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        if (accept) begin
            state_d  = SHIFT;
            shreg_d  = i_data;
            cnt_d    = FRAME_LEN_C;
            lsb_d    = i_lsb_first;
            first_d  = 1'b1;
`ifdef PISO_PARITY_EN
            parity_d = ^i_data;
`endif
        end else if ((state_q == SHIFT) && i_shift_en) begin
            shreg_d = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q - CNT_ONE;
            first_d = 1'b0;
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
            end
        end
    end

    // State registers with synchronous active-low reset; a reset mid-frame
    // discards whatever bits remain.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            lsb_q    <= 1'b0;
            first_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            lsb_q    <= lsb_d;
            first_q  <= first_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed, table-driven bench for piso_serializer at
// WIDTH=8. Expected outputs are packed as {sdata, svalid, first, last, ready}.
// The o_busy output is compared against the expected svalid value.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic             clk;
    logic             rstN;
    logic [WIDTH-1:0] dataIn;
    logic             loadValid;
    logic             loadReady;
    logic             lsbFirst;
    logic             shiftEn;
    logic             sData;
    logic             sValid;
    logic             firstFlag;
    logic             lastFlag;
    logic             busy;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct {
        logic       rstN;
        logic [7:0] data;
        logic       lv;
        logic       lsb;
        logic       sen;
        logic       chk;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_data       (dataIn),
        .i_load_valid (loadValid),
        .o_load_ready (loadReady),
        .i_lsb_first  (lsbFirst),
        .i_shift_en   (shiftEn),
        .o_sdata      (sData),
        .o_svalid     (sValid),
        .o_first      (firstFlag),
        .o_last       (lastFlag),
        .o_busy       (busy)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs on the falling edge, then settle before the outputs are sampled.
    task automatic applyStimulus(input logic r, input logic [7:0] d, input logic lv,
                                 input logic lsb, input logic sen);
        @(negedge clk);
        rstN      = r;
        dataIn    = d;
        loadValid = lv;
        lsbFirst  = lsb;
        shiftEn   = sen;
        #1;
    endtask

    // Compare all outputs against a packed expectation {sdata,svalid,first,last,ready}.
    task automatic checkOutput(input string name, input logic [4:0] e);
        logic [5:0] act;
        logic [5:0] req;
        act = {sData, sValid, busy, firstFlag, lastFlag, loadReady};
        req = {e[4], e[3], e[3], e[2], e[1], e[0]};
        checkCount++;
        if (act !== req) begin
            errorCount++;
            $display("[TB] FAIL %s: got {sd,sv,busy,first,last,rdy}=%b expected %b at %0t",
                     name, act, req, $time);
        end
    endtask

    // Append one stimulus/expectation record to the vector table.
    function automatic void addVec(input logic r, input logic [7:0] d, input logic lv,
                                   input logic lsb, input logic sen, input logic chk,
                                   input logic [4:0] e);
        vec_t v;
        v.rstN = r;
        v.data = d;
        v.lv   = lv;
        v.lsb  = lsb;
        v.sen  = sen;
        v.chk  = chk;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    // Offer a word while idle and confirm it is accepted.
    task automatic loadWord(input string name, input logic [7:0] d, input logic lsb);
        applyStimulus(1'b1, d, 1'b1, lsb, 1'b0);
        checkOutput(name, 5'b0_0_0_0_1);
    endtask

    // Walk one already-loaded frame. Optionally stall before each consume, and
    // optionally offer a chained word while the last bit is being consumed.
    task automatic checkFrame(input string name, input logic [7:0] d, input logic lsb,
                              input logic stall, input logic chainValid,
                              input logic [7:0] chainData);
        for (int k = 0; k < FL; k++) begin
            logic b;
            logic isFirst;
            logic isLast;
            if (k < WIDTH) b = lsb ? d[k] : d[WIDTH-1-k];
            else           b = ^d;
            isFirst = (k == 0);
            isLast  = (k == FL - 1);
            if (stall) begin
                applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
                checkOutput(name, {b, 1'b1, isFirst, isLast, 1'b0});
            end
            applyStimulus(1'b1, isLast ? chainData : 8'h00, isLast ? chainValid : 1'b0,
                          1'b0, 1'b1);
            checkOutput(name, {b, 1'b1, isFirst, isLast, isLast});
        end
    endtask

    initial begin
        rstN      = 1'b0;
        dataIn    = '0;
        loadValid = 1'b0;
        lsbFirst  = 1'b0;
        shiftEn   = 1'b0;

        // Reset, idle shift pulses, then an MSB-first 8'hA5 frame with an ignored mid-frame load.
        addVec(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0_0_0_0_0);
        addVec(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0_0_0_0_1);
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0_0_0_0_1);
        addVec(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 5'b0_0_0_0_1);
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0_0_0_0_1);
        addVec(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 5'b0_0_0_0_1);
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b1_1_1_0_0);
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0_1_0_0_0);
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b1_1_0_0_0);
        addVec(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 5'b0_1_0_0_0);
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0_1_0_0_0);
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b1_1_0_0_0);
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0_1_0_0_0);
`ifdef PISO_PARITY_EN
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b1_1_0_0_0);
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0_1_0_1_1);
`else
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b1_1_0_1_1);
`endif
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0_0_0_0_1);
        addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0_0_0_0_1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstN, vecs[i].data, vecs[i].lv, vecs[i].lsb, vecs[i].sen);
            if (vecs[i].chk) checkOutput($sformatf("table%0d", i), vecs[i].exp);
        end

        // LSB-first 8'hA5 with a stall cycle before every consume.
        loadWord("lsb_load", 8'hA5, 1'b1);
        checkFrame("lsb_stall", 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("lsb_idle", 5'b0_0_0_0_1);

        // Back-to-back frames 8'h3C then 8'hC3 with no gap cycle.
        loadWord("b2b_load", 8'h3C, 1'b0);
        checkFrame("b2b_first", 8'h3C, 1'b0, 1'b0, 1'b1, 8'hC3);
        checkFrame("b2b_second", 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b_idle", 5'b0_0_0_0_1);

        // Reset mid-frame discards the rest of 8'hFF, then a clean 8'h01 frame.
        loadWord("rst_load", 8'hFF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
            checkOutput("rst_pre", {1'b1, 1'b1, (k == 0), 1'b0, 1'b0});
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_edge", 5'b1_1_0_0_0);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_after", 5'b0_0_0_0_1);
        loadWord("rst_reload", 8'h01, 1'b0);
        checkFrame("rst_clean", 8'h01, 1'b0, 1'b0, 1'b0, 8'h00);

        // Frames whose parity differs; with parity enabled they gain a ninth bit.
        loadWord("par_load_a5", 8'hA5, 1'b0);
        checkFrame("par_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        loadWord("par_load_07", 8'h07, 1'b1);
        checkFrame("par_07", 8'h07, 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("final_idle", 5'b0_0_0_0_1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
